// File: rtl/keypad_pkg.sv
// Purpose: shared key map, scan/debounce state encodings, column drive patterns and frame classifier.
// Latency: none; types, constants and one combinational helper.
// Backpressure: not applicable.
package keypad_pkg;

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} scan_state_e;

    typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} deb_state_e;

    typedef enum logic [1:0] {FC_NONE, FC_SINGLE, FC_MULTI} frame_class_e;

    typedef struct packed {
        frame_class_e cls;
        logic [3:0]   code;
    } frame_t;

    // Column drive indexed by scan state: exactly one column pulled low.
    localparam logic [3:0][3:0] COL_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Key code indexed by {row, col}; row 0 is the top row of the pad.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Reduce a full frame of pressed-key flags to NONE / SINGLE(code) / MULTI.
    function automatic frame_t classify(input logic [15:0] hits);
        frame_t f;
        int     n;
        f.cls  = FC_NONE;
        f.code = 4'h0;
        n      = 0;
        for (int i = 0; i < 16; i++) begin
            if (hits[4'(i)]) begin
                n      = n + 1;
                f.code = KEY_MAP[4'(i)];
            end
        end
        if (n == 1) begin
            f.cls = FC_SINGLE;
        end else if (n > 1) begin
            f.cls = FC_MULTI;
        end
        return f;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Purpose: frame-level press/release debounce, key history and (KEYPAD_AUTOREPEAT_EN) auto-repeat.
// Latency: outputs register on the cycle after the frame strobe.
// Backpressure: none; key_valid_o is a one-cycle pulse with no handshake.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_FRAMES   = 250
`endif
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         frame_vld_i,
    input  frame_class_e frame_cls_i,
    input  logic [3:0]   frame_code_i,
    output logic [3:0]   key_code_o,
    output logic         key_valid_o,
    output logic         key_held_o,
    output logic [7:0]   number_out_o
);

    localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

    deb_state_e st_q, st_d;
    logic [3:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0] cand_q, cand_d;
    logic [3:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       held_q, held_d;
    logic [7:0] num_q, num_d;
    logic       accept;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int             RW       = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0]  RPT_LAST = RW'(REPEAT_FRAMES);
    logic [RW-1:0] rpt_q, rpt_d;
`endif

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st_q    <= RELEASED;
            cnt_q   <= 4'd0;
            cand_q  <= 4'd0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            num_q   <= 8'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            num_q   <= num_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    // Next-state: advance debounce once per evaluated frame
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        held_d  = held_q;
        num_d   = num_q;
        valid_d = 1'b0;
        accept  = 1'b0;
        cnt_inc = cnt_q + 4'd1;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_d   = rpt_q;
`endif
        if (frame_vld_i) begin
            case (st_q)
                RELEASED: begin
                    if (frame_cls_i == FC_SINGLE) begin
                        cand_d = frame_code_i;
                        cnt_d  = 4'd1;
                        if (DF == 4'd1) accept = 1'b1;
                        else            st_d   = PRESS_PEND;
                    end
                end
                PRESS_PEND: begin
                    // A MULTI frame neither advances nor breaks the run.
                    if (frame_cls_i == FC_SINGLE && frame_code_i == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DF) accept = 1'b1;
                    end else if (frame_cls_i != FC_MULTI) begin
                        st_d  = RELEASED;
                        cnt_d = 4'd0;
                    end
                end
                PRESSED: begin
                    if (frame_cls_i == FC_NONE) begin
                        if (DF == 4'd1) begin
                            st_d   = RELEASED;
                            held_d = 1'b0;
                            cnt_d  = 4'd0;
                        end else begin
                            st_d  = RELEASE_PEND;
                            cnt_d = 4'd1;
                        end
                    end else if (frame_cls_i == FC_SINGLE && frame_code_i != code_q) begin
                        st_d  = RELEASE_PEND;
                        cnt_d = 4'd0;
                    end
                end
                RELEASE_PEND: begin
                    // Only consecutive empty frames count towards a release.
                    if (frame_cls_i == FC_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DF) begin
                            st_d   = RELEASED;
                            held_d = 1'b0;
                            cnt_d  = 4'd0;
                        end
                    end else if (frame_cls_i == FC_SINGLE && frame_code_i == code_q) begin
                        st_d  = PRESSED;
                        cnt_d = 4'd0;
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                default: st_d = RELEASED;
            endcase
        end
        if (accept) begin
            st_d    = PRESSED;
            cnt_d   = 4'd0;
            code_d  = cand_d;
            valid_d = 1'b1;
            held_d  = 1'b1;
            num_d   = {num_q[3:0], cand_d};
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        // Repeat timer runs while the key is held, including release-pending frames.
        if (frame_vld_i) begin
            if (accept) begin
                rpt_d = '0;
            end else if ((st_q == PRESSED || st_q == RELEASE_PEND) && st_d != RELEASED) begin
                if (rpt_q + RW'(1) == RPT_LAST) begin
                    rpt_d   = '0;
                    valid_d = 1'b1;
                    num_d   = {num_q[3:0], code_q};
                end else begin
                    rpt_d = rpt_q + RW'(1);
                end
            end
        end
`endif
    end

    // Outputs come straight from registers
    always_comb begin
        key_code_o   = code_q;
        key_valid_o  = valid_q;
        key_held_o   = held_q;
        number_out_o = num_q;
    end

endmodule

// File: rtl/keypad_scanner.sv
// Purpose: 4x4 keypad column scanner, row synchronizer and frame classifier; optional auto-repeat via KEYPAD_AUTOREPEAT_EN.
// Latency: rows 2-cycle sync; key outputs update one cycle after the COL3 sample closing each 4*SCAN_CYCLES frame.
// Backpressure: none; free-running scan, key_valid_o is an unacknowledged pulse.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 100000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 250
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_held_o,
    output logic [7:0] number_out_o
);

    localparam int            CW       = $clog2(SCAN_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CYCLES - 1);

    if (SCAN_CYCLES < 4) begin : g_chk_scan
        $error("SCAN_CYCLES must be at least 4");
    end
    if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_chk_deb
        $error("DEBOUNCE_FRAMES must be within 1..15");
    end
    if (REPEAT_FRAMES < 1) begin : g_chk_rpt
        $error("REPEAT_FRAMES must be at least 1");
    end

    logic [3:0]    row_s1_q, row_s2_q;
    scan_state_e   scan_st_q, scan_st_d;
    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic [15:0]   hits_q, hits_d;
    logic          sample;
    logic          frame_vld;
    frame_t        frame;

    // Two-flop synchronizer for the asynchronous, pulled-up rows
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row_i;
            row_s2_q <= row_s1_q;
        end
    end

    // Scan state, dwell counter and per-frame key flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scan_st_q  <= COL0;
            scan_cnt_q <= '0;
            hits_q     <= 16'h0000;
        end else begin
            scan_st_q  <= scan_st_d;
            scan_cnt_q <= scan_cnt_d;
            hits_q     <= hits_d;
        end
    end

    assign sample = (scan_cnt_q == CNT_LAST);

    // Next column after the dwell's final (sampling) cycle
    always_comb begin
        scan_st_d  = scan_st_q;
        scan_cnt_d = scan_cnt_q + CW'(1);
        if (sample) begin
            scan_cnt_d = '0;
            case (scan_st_q)
                COL0:    scan_st_d = COL1;
                COL1:    scan_st_d = COL2;
                COL2:    scan_st_d = COL3;
                COL3:    scan_st_d = COL0;
                default: scan_st_d = COL0;
            endcase
        end
    end

    // Capture the active column's rows; a low row means that key is down
    always_comb begin
        hits_d = hits_q;
        if (sample) begin
            for (int r = 0; r < 4; r++) begin
                hits_d[{2'(r), scan_st_q}] = ~row_s2_q[r];
            end
        end
    end

    // Column drive follows the scan state
    always_comb begin
        col_o = COL_DRIVE[scan_st_q];
    end

    // The COL3 sample closes the frame; hits_d already includes that column.
    assign frame_vld = sample && (scan_st_q == COL3);
    assign frame     = classify(hits_d);

    keypad_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .REPEAT_FRAMES   (REPEAT_FRAMES)
`endif
    ) u_debounce (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .frame_vld_i  (frame_vld),
        .frame_cls_i  (frame.cls),
        .frame_code_i (frame.code),
        .key_code_o   (key_code_o),
        .key_valid_o  (key_valid_o),
        .key_held_o   (key_held_o),
        .number_out_o (number_out_o)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose: self-checking bench for keypad_scanner with a behavioural 4x4 key matrix.
// Latency: one frame is 32 cycles (SCAN_CYCLES=8); key pulses expected at cycle 32*frame after reset release.
// Backpressure: not applicable.
module tb_keypad_scanner;

    typedef struct {
        logic [15:0] keys;
        int          frames;
        int          pulse_frame;
        logic [3:0]  code;
        logic [7:0]  num;
        logic        held;
    } vec_t;

    typedef struct {
        logic [3:0] code;
        logic [7:0] num;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [7:0]  number_out;
    logic [15:0] keys;
    int          cyc;
    int          n_pass = 0;
    int          n_total = 0;
    exp_t        sb[$];
    vec_t        vecs[22];
    logic [3:0]  colpat[4];

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_CYCLES     (8),
        .DEBOUNCE_FRAMES (2),
        .REPEAT_FRAMES   (4)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .row_i        (row),
        .col_o        (col),
        .key_code_o   (key_code),
        .key_valid_o  (key_valid),
        .key_held_o   (key_held),
        .number_out_o (number_out)
    );

    // Key matrix: a held key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard: every KeyValid pulse must match the oldest expected pulse.
    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            exp_t e;
            check("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_code", 32'(key_code), 32'(e.code));
                check("pulse_number", 32'(number_out), 32'(e.num));
            end
        end
    end

    // Hold a key pattern for whole frames, then check the settled outputs.
    task automatic apply(input vec_t v);
        int fb;
        fb   = cyc / 32;
        keys = v.keys;
        if (v.pulse_frame != 0) sb.push_back('{v.code, v.num, 32 * (fb + v.pulse_frame)});
        repeat (32 * v.frames) @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        check("key_code", 32'(key_code), 32'(v.code));
        check("number_out", 32'(number_out), 32'(v.num));
        check("key_held", 32'(key_held), 32'(v.held));
    endtask

    initial begin
        colpat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        //          keys      frames pulse code   num    held
        vecs[0]  = '{16'h0040, 3, 2, 4'h6, 8'h06, 1'b1};  // "6" accepted at frame 2
        vecs[1]  = '{16'h0000, 1, 0, 4'h6, 8'h06, 1'b1};  // release pending
        vecs[2]  = '{16'h0000, 1, 0, 4'h6, 8'h06, 1'b0};  // held falls 2 frames after release
        vecs[3]  = '{16'h0800, 2, 2, 4'hC, 8'h6C, 1'b1};  // "C"
        vecs[4]  = '{16'h0000, 1, 0, 4'hC, 8'h6C, 1'b1};
        vecs[5]  = '{16'h0000, 1, 0, 4'hC, 8'h6C, 1'b0};
        vecs[6]  = '{16'h0020, 1, 0, 4'hC, 8'h6C, 1'b0};  // bouncing "5"
        vecs[7]  = '{16'h0000, 1, 0, 4'hC, 8'h6C, 1'b0};
        vecs[8]  = '{16'h0020, 1, 0, 4'hC, 8'h6C, 1'b0};
        vecs[9]  = '{16'h0000, 1, 0, 4'hC, 8'h6C, 1'b0};
        vecs[10] = '{16'h0021, 3, 0, 4'hC, 8'h6C, 1'b0};  // "1"+"5" together
        vecs[11] = '{16'h0002, 2, 2, 4'h2, 8'hC2, 1'b1};  // "2"
        vecs[12] = '{16'h0004, 2, 0, 4'h2, 8'hC2, 1'b1};  // roll to "3" without release
        vecs[13] = '{16'h0000, 2, 0, 4'h2, 8'hC2, 1'b0};
        vecs[14] = '{16'h0400, 2, 2, 4'h9, 8'h29, 1'b1};  // "9"
        vecs[15] = '{16'h0000, 1, 0, 4'h9, 8'h29, 1'b1};  // release glitch
        vecs[16] = '{16'h0400, 1, 0, 4'h9, 8'h29, 1'b1};  // back to pressed, no pulse
        vecs[17] = '{16'h0000, 2, 0, 4'h9, 8'h29, 1'b0};
        vecs[18] = '{16'h0010, 1, 0, 4'h9, 8'h29, 1'b0};  // "4" pending
        vecs[19] = '{16'h0210, 1, 0, 4'h9, 8'h29, 1'b0};  // MULTI holds count
        vecs[20] = '{16'h0010, 1, 1, 4'h4, 8'h94, 1'b1};  // second matching frame accepts
        vecs[21] = '{16'h0000, 2, 0, 4'h4, 8'h94, 1'b0};

        rst_n = 1'b0;
        keys  = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col), 32'h0000000E);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_number", 32'(number_out), 32'd0);

        rst_n = 1'b1;
        for (int t = 0; t < 64; t++) begin
            check("col_scan", 32'(col), 32'(colpat[(t / 8) % 4]));
            @(negedge clk);
        end
        #1;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset in the middle of a pending press: no pulse, everything cleared.
        keys = 16'h0100;
        repeat (52) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(key_valid), 32'd0);
        check("midrst_held", 32'(key_held), 32'd0);
        check("midrst_code", 32'(key_code), 32'd0);
        check("midrst_number", 32'(number_out), 32'd0);
        check("midrst_col", 32'(col), 32'h0000000E);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("restart_col", 32'(col), 32'h0000000E);
        apply('{16'h0100, 2, 2, 4'h7, 8'h07, 1'b1});
        apply('{16'h0000, 2, 0, 4'h7, 8'h07, 1'b0});

`ifdef KEYPAD_AUTOREPEAT_EN
        begin
            int fb;
            fb = cyc / 32;
            sb.push_back('{4'hA, 8'h7A, 32 * (fb + 2)});
            sb.push_back('{4'hA, 8'hAA, 32 * (fb + 6)});
            sb.push_back('{4'hA, 8'hAA, 32 * (fb + 10)});
            sb.push_back('{4'hA, 8'hAA, 32 * (fb + 14)});
            apply('{16'h0008, 14, 0, 4'hA, 8'hAA, 1'b1});
            apply('{16'h0000, 2, 0, 4'hA, 8'hAA, 1'b0});
        end
`endif

        check("sb_empty_end", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
